pc_sequencer: RTL and testbench

Program-counter stage that consumes the 16-bit jump target after its upper nibble has been cleared to 0 by the address-forcing stage. Holds the 12-bit instruction address space of the processor and selects the next PC from jump, relative branch, call/return or sequential increment. Drives the instruction-memory address and supplies the return address to the datapath.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/ret_stack.sv | 46 ++++
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants and enums for the program-counter sequencer.
package pc_pkg;

  localparam int              ADDR_W      = 12;
  localparam int              DATA_W      = 16;
  localparam logic [ADDR_W-1:0] RESET_PC  = 12'h000;
  localparam int              STACK_DEPTH = 4;

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_INC
  } sel_t;

endpackage

// File: rtl/ret_stack.sv
// Pointer-based LIFO holding return addresses for call/return.
module ret_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int W     = ADDR_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_pushData,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_top
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   r_count;
  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] w_topIdx;

  assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_topIdx = r_count[PTR_W-1:0] - PTR_W'(1);
  assign o_top    = r_mem[w_topIdx];

  // Occupancy count doubles as the write pointer; contents are discarded by clearing it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_count <= r_count + (PTR_W+1)'(1);
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) begin
      r_mem[r_count[PTR_W-1:0]] <= i_pushData;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: jump, relative branch, call/return, increment.
// Return stack is built only when PC_RET_STACK_EN is defined.
module pc_sequencer
  import pc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              jumpEn,
  input  logic [DATA_W-1:0] jumpTarget,
  input  logic              branchEn,
  input  logic [DATA_W-1:0] branchOffset,
  input  logic              callEn,
  input  logic              retEn,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pcPlus1,
  output logic              valid,
  output logic              stackOverflow,
  output logic              stackUnderflow
);

  state_t              r_state;
  state_t              w_stateNext;
  sel_t                w_sel;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pcNext;
  logic [ADDR_W-1:0]   w_pcInc;
  logic [ADDR_W-1:0]   w_retAddr;
  logic                w_active;
  logic                w_unusedBits;

  assign w_pcInc  = r_pc + ADDR_W'(1);
  assign w_active = (r_state == RUN) && !stall;
  assign pc       = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
  assign pcPlus1  = {{(DATA_W-ADDR_W){1'b0}}, w_pcInc};
  assign valid    = (r_state == RUN);

`ifdef PC_RET_STACK_EN
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic r_overflow;
  logic r_underflow;

  assign w_push = (w_sel == SEL_CALL) && !w_full;
  assign w_pop  = (w_sel == SEL_RET);

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_pushData (w_pcInc),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_top      (w_retAddr)
  );

  // Sticky error flags; only a reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if ((w_sel == SEL_CALL) && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_active && retEn && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign stackOverflow  = r_overflow;
  assign stackUnderflow = r_underflow;
  assign w_unusedBits   = &{1'b0, jumpTarget[DATA_W-1:ADDR_W], branchOffset[DATA_W-1:ADDR_W]};
`else
  assign w_retAddr      = r_pc;
  assign stackOverflow  = 1'b0;
  assign stackUnderflow = 1'b0;
  assign w_unusedBits   = &{1'b0, retEn, jumpTarget[DATA_W-1:ADDR_W], branchOffset[DATA_W-1:ADDR_W]};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
    end
  end

  // Request priority: stall > ret > call > jump > branch > increment.
  always_comb begin
    w_stateNext = RUN;
    w_sel       = SEL_HOLD;
    if (w_active) begin
`ifdef PC_RET_STACK_EN
      if (retEn) begin
        w_sel = w_empty ? SEL_INC : SEL_RET;
      end else if (callEn) begin
        w_sel = SEL_CALL;
      end else if (jumpEn) begin
        w_sel = SEL_JUMP;
      end else if (branchEn) begin
        w_sel = SEL_BRANCH;
      end else begin
        w_sel = SEL_INC;
      end
`else
      if (callEn || jumpEn) begin
        w_sel = SEL_JUMP;
      end else if (branchEn) begin
        w_sel = SEL_BRANCH;
      end else begin
        w_sel = SEL_INC;
      end
`endif
    end
  end

  always_comb begin
    w_pcNext = r_pc;
    case (w_sel)
      SEL_RET:    w_pcNext = w_retAddr;
      SEL_CALL:   w_pcNext = jumpTarget[ADDR_W-1:0];
      SEL_JUMP:   w_pcNext = jumpTarget[ADDR_W-1:0];
      SEL_BRANCH: w_pcNext = r_pc + branchOffset[ADDR_W-1:0];
      SEL_INC:    w_pcNext = w_pcInc;
      default:    w_pcNext = r_pc;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a queue-based PC model.
// Model follows PC_RET_STACK_EN the same way the design does.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        jumpEn;
  logic [15:0] jumpTarget;
  logic        branchEn;
  logic [15:0] branchOffset;
  logic        callEn;
  logic        retEn;
  logic [15:0] pc;
  logic [15:0] pcPlus1;
  logic        valid;
  logic        stackOverflow;
  logic        stackUnderflow;

  int checks = 0;
  int errors = 0;

  int mPc;
  int mStack[$];
  bit mOvf;
  bit mUdf;
  bit mValid;
  bit mBoot;

  logic [34:0] obsVec;
  assign obsVec = {valid, stackOverflow, stackUnderflow, pc, pcPlus1};

  pc_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .jumpEn         (jumpEn),
    .jumpTarget     (jumpTarget),
    .branchEn       (branchEn),
    .branchOffset   (branchOffset),
    .callEn         (callEn),
    .retEn          (retEn),
    .pc             (pc),
    .pcPlus1        (pcPlus1),
    .valid          (valid),
    .stackOverflow  (stackOverflow),
    .stackUnderflow (stackUnderflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit stackOn();
`ifdef PC_RET_STACK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void modelReset();
    mPc    = 0;
    mStack = {};
    mOvf   = 1'b0;
    mUdf   = 1'b0;
    mValid = 1'b0;
    mBoot  = 1'b1;
  endfunction

  // One clock edge of the architectural PC rules, using inputs as sampled at the edge.
  function automatic void modelEdge();
    if (mBoot) begin
      mBoot  = 1'b0;
      mValid = 1'b1;
      return;
    end
    if (stall) return;
    if (stackOn() && retEn) begin
      if (mStack.size() > 0) mPc = mStack.pop_back();
      else begin
        mPc  = (mPc + 1) % 4096;
        mUdf = 1'b1;
      end
    end else if (stackOn() && callEn) begin
      if (mStack.size() < DEPTH) mStack.push_back((mPc + 1) % 4096);
      else mOvf = 1'b1;
      mPc = int'(jumpTarget) % 4096;
    end else if (callEn || jumpEn) begin
      mPc = int'(jumpTarget) % 4096;
    end else if (branchEn) begin
      mPc = (mPc + int'(branchOffset)) % 4096;
    end else begin
      mPc = (mPc + 1) % 4096;
    end
  endfunction

  function automatic logic [34:0] expVec();
    return {mValid, mOvf, mUdf, 16'(mPc), 16'((mPc + 1) % 4096)};
  endfunction

  task automatic applyStimulus(input logic s, input logic j, input logic [15:0] jt,
                               input logic b, input logic [15:0] bo,
                               input logic c, input logic r);
    stall        = s;
    jumpEn       = j;
    jumpTarget   = jt;
    branchEn     = b;
    branchOffset = bo;
    callEn       = c;
    retEn        = r;
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 0);
    reset_n = 1'b0;
    modelReset();
    #2;
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL reset_held: got %h expected %h", obsVec, expVec());
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL reset_released: got %h expected %h", obsVec, expVec());
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL boot_seq cycle %0d: got %h expected %h", i, obsVec, expVec());
      end
    end
  endtask

  task automatic test_jump_wrap();
    applyStimulus(0, 1, 16'h0FFE, 0, 16'h0, 0, 0);
    step();
    applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 0);
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL jump: got %h expected %h", obsVec, expVec());
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obsVec !== expVec() || pc[15:12] !== 4'h0) begin
        errors++;
        $display("[TB] FAIL wrap cycle %0d: got %h expected %h", i, obsVec, expVec());
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] offsets [2];
    offsets[0] = 16'hFFF0;
    offsets[1] = 16'h0020;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 16'h0010, 0, 16'h0, 0, 0);
      step();
      applyStimulus(0, 0, 16'h0, 1, offsets[i], 0, 0);
      step();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL branch off=%h: got %h expected %h", offsets[i], obsVec, expVec());
      end
    end
    applyStimulus(0, 1, 16'h0002, 0, 16'h0, 0, 0);
    step();
    applyStimulus(0, 0, 16'h0, 1, 16'hFFFC, 0, 0);
    step();
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL branch_back: got %h expected %h", obsVec, expVec());
    end
  endtask

  task automatic test_call_return();
    applyStimulus(0, 1, 16'h0005, 0, 16'h0, 0, 0);
    step();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 0, 16'(i * 16'h0100), 0, 16'h0, 1, 0);
      step();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL call %0d: got %h expected %h", i, obsVec, expVec());
      end
    end
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 1);
      step();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL return %0d: got %h expected %h", i, obsVec, expVec());
      end
    end
  endtask

  task automatic test_stall();
    applyStimulus(0, 0, 16'h0123, 0, 16'h0, 1, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 16'h0777, 1, 16'h0040, 1, 1);
      step();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL stall cycle %0d: got %h expected %h", i, obsVec, expVec());
      end
    end
    applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 1);
    step();
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL stall_release_ret: got %h expected %h", obsVec, expVec());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 16'(16'h0200 + i), 0, 16'h0, 1, 0);
      step();
    end
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h", obsVec, expVec());
    end
    applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 1);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL post_reset_boot: got %h expected %h", obsVec, expVec());
    end
    step();
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL post_reset_underflow: got %h expected %h", obsVec, expVec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [15:0] jt;
      jt = 16'($urandom);
      if ($urandom_range(0, 3) != 0) jt[15:12] = 4'h0;
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, jt,
                    $urandom_range(0, 4) == 0, 16'($urandom),
                    $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
      step();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", i, obsVec, expVec());
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 0);
    test_reset();
    test_jump_wrap();
    test_branch();
    test_call_return();
    test_stall();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
